// File: rtl/uart_bridge_router.sv
// rtl/uart_bridge_router.sv - N-channel UART byte crossbar with per-destination FIFOs and TX sequencers
module uart_bridge_router #(
  parameter int NCH     = 2,
  parameter int DW      = 8,
  parameter int FIFO_AW = 4,
  parameter int TXTO    = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH*DW-1:0]      rx_data,
  input  logic [NCH-1:0]         rx_done,
  input  logic [DW-1:0]          inj_data,
  input  logic                   inj_btn,
  input  logic [(NCH+1)*NCH-1:0] route_map,
  output logic [NCH*DW-1:0]      tx_data,
  output logic [NCH-1:0]         tx_en,
  input  logic [NCH-1:0]         tx_busy,
  output logic [DW-1:0]          last_data,
  output logic                   last_wr,
  output logic [NCH-1:0]         fifo_full,
  output logic [NCH-1:0]         fifo_empty,
  output logic [7:0]             drop_cnt
);
  localparam int NS    = NCH + 1;
  localparam int SW    = $clog2(NS);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TXTO + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} tx_state_t;

  logic [NS-1:0]      src_lvl, src_q, src_edge, hold_v, grant_oh, cap_drop;
  logic [DW-1:0]      src_byte [NS];
  logic [DW-1:0]      hold_d   [NS];
  logic               live, grant_v;
  logic [SW-1:0]      rr, grant;
  logic [DW-1:0]      gbyte;
  logic [NCH-1:0]     row, pop, wr_ok, fifo_drop, tx_to;
  logic [FIFO_AW-1:0] wptr [NCH];
  logic [FIFO_AW-1:0] rptr [NCH];
  logic [FIFO_AW:0]   cnt  [NCH];
  logic [DW-1:0]      mem  [NCH][DEPTH];
  tx_state_t          st    [NCH];
  tx_state_t          st_nx [NCH];
  logic [TW-1:0]      tmr   [NCH];
  logic [5:0]         drop_sum;
  logic [8:0]         drop_tot;

  // live stays low for the first cycle after reset so a level already high is not an edge
  assign src_lvl  = {inj_btn, rx_done};
  assign src_edge = live ? (src_lvl & ~src_q) : '0;

  always_comb begin
    for (int c = 0; c < NCH; c++) src_byte[c] = rx_data[c*DW +: DW];
    src_byte[NCH] = inj_data;
  end

  // lowest held source at or above rr wins, else lowest held source overall
  always_comb begin
    grant_v = 1'b0;
    grant   = '0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (hold_v[s]) begin
        grant_v = 1'b1;
        grant   = SW'(s);
      end
    end
    for (int s = NS - 1; s >= 0; s--) begin
      if (hold_v[s] && (SW'(s) >= rr)) grant = SW'(s);
    end
  end

  always_comb begin
    grant_oh = '0;
    gbyte    = '0;
    row      = '0;
    for (int s = 0; s < NS; s++) begin
      grant_oh[s] = grant_v && (grant == SW'(s));
      if (grant_oh[s]) begin
        gbyte = hold_d[s];
        row   = route_map[s*NCH +: NCH];
      end
    end
  end

  always_comb begin
    fifo_full  = '0;
    fifo_empty = '0;
    pop        = '0;
    wr_ok      = '0;
    fifo_drop  = '0;
    for (int d = 0; d < NCH; d++) begin
      fifo_full[d]  = (cnt[d] == (FIFO_AW+1)'(DEPTH));
      fifo_empty[d] = (cnt[d] == '0);
      pop[d]        = (st[d] == IDLE) && !fifo_empty[d];
      wr_ok[d]      = row[d] && (!fifo_full[d] || pop[d]);
      fifo_drop[d]  = row[d] && fifo_full[d] && !pop[d];
    end
  end

  always_comb begin
    drop_sum = '0;
    cap_drop = '0;
    for (int s = 0; s < NS; s++) begin
      cap_drop[s] = src_edge[s] && hold_v[s] && !grant_oh[s];
      drop_sum    = drop_sum + 6'(cap_drop[s]);
    end
    for (int d = 0; d < NCH; d++) drop_sum = drop_sum + 6'(fifo_drop[d]) + 6'(tx_to[d]);
    drop_tot = 9'(drop_cnt) + 9'(drop_sum);
  end

  always_comb begin
    tx_en = '0;
    tx_to = '0;
    for (int c = 0; c < NCH; c++) begin
      st_nx[c] = st[c];
      case (st[c])
        IDLE:    if (pop[c]) st_nx[c] = START;
        START: begin
          tx_en[c] = 1'b1;
          st_nx[c] = WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy[c]) st_nx[c] = WAIT_LO;
          else if (tmr[c] == TW'(TXTO - 1)) begin
            st_nx[c] = IDLE;
            tx_to[c] = 1'b1;
          end
        end
        WAIT_LO: if (!tx_busy[c]) st_nx[c] = IDLE;
        default: st_nx[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) st[c] <= IDLE;
    end else begin
      for (int c = 0; c < NCH; c++) st[c] <= st_nx[c];
    end
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < NCH; d++) begin
      if (wr_ok[d]) mem[d][wptr[d]] <= gbyte;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live      <= 1'b0;
      src_q     <= '0;
      hold_v    <= '0;
      rr        <= '0;
      last_data <= '0;
      last_wr   <= 1'b0;
      drop_cnt  <= '0;
      tx_data   <= '0;
      for (int s = 0; s < NS; s++) hold_d[s] <= '0;
      for (int c = 0; c < NCH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
        tmr[c]  <= '0;
      end
    end else begin
      live    <= 1'b1;
      src_q   <= src_lvl;
      last_wr <= grant_v;
      if (grant_v) begin
        last_data <= gbyte;
        rr        <= (grant == SW'(NS - 1)) ? '0 : grant + 1'b1;
      end
      drop_cnt <= (drop_tot > 9'd255) ? 8'hFF : drop_tot[7:0];
      // a fresh edge reloads the hold even in its grant cycle, so nothing is lost there
      for (int s = 0; s < NS; s++) begin
        if (src_edge[s]) begin
          hold_d[s] <= src_byte[s];
          hold_v[s] <= 1'b1;
        end else if (grant_oh[s]) begin
          hold_v[s] <= 1'b0;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (wr_ok[c]) wptr[c] <= wptr[c] + 1'b1;
        if (pop[c]) begin
          rptr[c] <= rptr[c] + 1'b1;
          tx_data[c*DW +: DW] <= mem[c][rptr[c]];
        end
        if (wr_ok[c] && !pop[c]) cnt[c] <= cnt[c] + 1'b1;
        else if (!wr_ok[c] && pop[c]) cnt[c] <= cnt[c] - 1'b1;
        if (st[c] == START) tmr[c] <= '0;
        else if (st[c] == WAIT_HI) tmr[c] <= tmr[c] + 1'b1;
      end
    end
  end
endmodule
